// File: rtl/sram_lane_wr_macro_pkg.sv
// Shared lane geometry and control constants for the lane-writable SRAM macro model
// and the packing wrappers that sit above it.
package sram_lane_wr_macro_pkg;

  localparam int LW    = 6;
  localparam int LANES = 8;
  localparam int DW    = LANES * LW;

  localparam logic [LANES-1:0] WEN_IDLE = 8'hFF;

  // A cycle is a read only when the chip is enabled and no lane is being written.
  function automatic logic is_read(input logic cen, input logic [LANES-1:0] wen);
    return (cen == 1'b0) && (wen == WEN_IDLE);
  endfunction

endpackage

// File: rtl/sram_lane_bank.sv
// One DEPTH x LW storage column of the macro; written under a single enable and read
// asynchronously so that the top level owns the only output register.
module sram_lane_bank
  import sram_lane_wr_macro_pkg::*;
#(
  parameter int DEPTH = 8192,
  parameter int AW    = 13
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [LW-1:0] din,
  output logic [LW-1:0] rdata
);

  logic [LW-1:0] mem_r [DEPTH];

  // Array write; contents are never reset.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_r[addr] <= din;
    end else begin
      mem_r[addr] <= mem_r[addr];
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/sram_lane_wr_macro.sv
// Behavioural DEPTH x 48 single-port SRAM macro built from eight independently
// writable 6-bit lanes, with a registered read port cleared by RSTN.
module sram_lane_wr_macro
  import sram_lane_wr_macro_pkg::*;
#(
  parameter int DEPTH = 8192,
  parameter int AW    = 13
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             CEN,
  input  logic [LANES-1:0] WEN,
  input  logic [AW-1:0]    A,
  input  logic [DW-1:0]    D,
  output logic [DW-1:0]    Q
);

  logic             in_range_s;
  logic             ctrl_known_s;
  logic [LANES-1:0] lane_we_s;
  logic [DW-1:0]    bank_word_s;
  logic [DW-1:0]    rd_word_s;
  logic [DW-1:0]    q_r;

  // Address range and control validity; unknown control must never reach the array.
  always_comb begin
    in_range_s   = 1'b0;
    ctrl_known_s = 1'b0;
    if (32'(A) < DEPTH) begin
      in_range_s = 1'b1;
    end else begin
      in_range_s = 1'b0;
    end
    if ($isunknown({CEN, WEN})) begin
      ctrl_known_s = 1'b0;
    end else begin
      ctrl_known_s = 1'b1;
    end
  end

  // Per-lane write strobes; out-of-range writes are dropped.
  always_comb begin
    lane_we_s = {LANES{1'b0}};
    if (ctrl_known_s && (CEN == 1'b0) && in_range_s) begin
      lane_we_s = ~WEN;
    end else begin
      lane_we_s = {LANES{1'b0}};
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sram_lane_bank #(
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_bank (
      .CLK   (CLK),
      .we    (lane_we_s[i]),
      .addr  (A),
      .din   (D[i*LW +: LW]),
      .rdata (bank_word_s[i*LW +: LW])
    );
  end

  // Out-of-range reads return zero rather than whatever the array index aliases to.
  always_comb begin
    rd_word_s = {DW{1'b0}};
    if (in_range_s) begin
      rd_word_s = bank_word_s;
    end else begin
      rd_word_s = {DW{1'b0}};
    end
  end

  // Output register: loads only on reads; unknown control poisons Q in simulation.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      q_r <= {DW{1'b0}};
    end else if (!ctrl_known_s) begin
      q_r <= {DW{1'bx}};
    end else if (is_read(CEN, WEN)) begin
      q_r <= rd_word_s;
    end else begin
      q_r <= q_r;
    end
  end

  assign Q = q_r;

endmodule

// File: tb/tb_sram_lane_wr_macro.sv
// Directed self-checking bench for sram_lane_wr_macro in its 8192x48 configuration.
module tb_sram_lane_wr_macro;

  logic        CLK;
  logic        RSTN;
  logic        CEN;
  logic [7:0]  WEN;
  logic [12:0] A;
  logic [47:0] D;
  logic [47:0] Q;

  int n_total;
  int n_pass;
  int n_fail;

  sram_lane_wr_macro #(
    .DEPTH (8192),
    .AW    (13)
  ) dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .CEN  (CEN),
    .WEN  (WEN),
    .A    (A),
    .D    (D),
    .Q    (Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [12:0] addr, input logic [7:0] wen, input logic [47:0] data);
    CEN = 1'b0; WEN = wen; A = addr; D = data;
    step();
  endtask

  task automatic rd(input logic [12:0] addr);
    CEN = 1'b0; WEN = 8'hFF; A = addr; D = 48'h0;
    step();
  endtask

  task automatic idle();
    CEN = 1'b1; WEN = 8'hFF; A = 13'd0; D = 48'h0;
    step();
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    RSTN = 1'b1; CEN = 1'b1; WEN = 8'hFF; A = 13'd0; D = 48'h0;

    // Async reset asserted mid-cycle
    #12;
    RSTN = 1'b0;
    #1;
    chk("reset_async", Q, 48'h0);
    step();
    chk("reset_hold", Q, 48'h0);
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("idle_after_reset", Q, 48'h0);
    end

    // Full-word write then read
    wr(13'd5, 8'h00, 48'h123456789ABC);
    chk("q_hold_during_write", Q, 48'h0);
    rd(13'd5);
    chk("full_read", Q, 48'h123456789ABC);
    idle();
    chk("q_hold_idle", Q, 48'h123456789ABC);

    // Single-lane writes
    wr(13'd5, 8'hFE, 48'h00000000003F);
    chk("q_hold_lane_write", Q, 48'h123456789ABC);
    rd(13'd5);
    chk("lane0_read", Q, 48'h123456789ABF);
    wr(13'd5, 8'h7F, 48'hFC0000000000);
    rd(13'd5);
    chk("lane7_read", Q, 48'hFE3456789ABF);

    // Chip disabled with all lanes enabled must not write
    CEN = 1'b1; WEN = 8'h00; A = 13'd5; D = 48'h0;
    step();
    chk("cen_hold_q", Q, 48'hFE3456789ABF);
    rd(13'd5);
    chk("cen_no_write", Q, 48'hFE3456789ABF);

    // Boundary addresses
    wr(13'd8191, 8'h00, 48'hAAAAAAAAAAAA);
    wr(13'd0,    8'h00, 48'h555555555555);
    rd(13'd8191);
    chk("top_addr", Q, 48'hAAAAAAAAAAAA);
    rd(13'd0);
    chk("addr_zero", Q, 48'h555555555555);
    rd(13'd5);
    chk("addr5_intact", Q, 48'hFE3456789ABF);

    // Multi-lane write followed immediately by a read of the same word
    wr(13'd0, 8'hF0, 48'hFFFFFFFFFFFF);
    rd(13'd0);
    chk("multi_lane_b2b", Q, 48'h555555FFFFFF);
    idle();
    chk("read_data_held", Q, 48'h555555FFFFFF);

    // Reset mid-operation retains array
    wr(13'd7, 8'h00, 48'h0F0F0F0F0F0F);
    rd(13'd8191);
    chk("pre_reset_read", Q, 48'hAAAAAAAAAAAA);
    #2;
    RSTN = 1'b0;
    #1;
    chk("reset_mid_op", Q, 48'h0);
    #2;
    RSTN = 1'b1;
    idle();
    chk("post_reset_idle", Q, 48'h0);
    rd(13'd7);
    chk("array_retained", Q, 48'h0F0F0F0F0F0F);
    rd(13'd0);
    chk("array_retained_0", Q, 48'h555555FFFFFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
